// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
//   Bundles every bus signal around alu_arbiter: two command requesters, the
//   ALU operand/result pins, the tagged response channel and the status
//   outputs (sticky parity error, completed-operation counter).
//
//   modport master : the arbiter side. It grants requesters, drives the ALU
//                    and sources responses.
//   modport slave  : the environment side. It holds the requesters, the ALU
//                    instance and the response consumer.
//
//   Signals
//     r0_valid/r0_ready, r0_a, r0_b, r0_sel : requester 0 command channel
//     r1_valid/r1_ready, r1_a, r1_b, r1_sel : requester 1 command channel
//     alu_a, alu_b, alu_sel                 : operands/opcode to the ALU
//     alu_res, alu_par                      : ALU result and its parity bit
//     rsp_valid/rsp_ready, rsp_id, rsp_data,
//     rsp_par, rsp_err                      : response channel
//     par_err                               : sticky parity-mismatch flag
//     op_count                              : completed responses (wraps)
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int CNT_W = 16
);
  // Requester 0
  logic             r0_valid;
  logic             r0_ready;
  logic [3:0]       r0_a;
  logic [3:0]       r0_b;
  logic [2:0]       r0_sel;
  // Requester 1
  logic             r1_valid;
  logic             r1_ready;
  logic [3:0]       r1_a;
  logic [3:0]       r1_b;
  logic [2:0]       r1_sel;
  // ALU pins
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [2:0]       alu_sel;
  logic [7:0]       alu_res;
  logic             alu_par;
  // Response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [7:0]       rsp_data;
  logic             rsp_par;
  logic             rsp_err;
  // Status
  logic             par_err;
  logic [CNT_W-1:0] op_count;

  modport master (
    input  r0_valid, r0_a, r0_b, r0_sel,
    output r0_ready,
    input  r1_valid, r1_a, r1_b, r1_sel,
    output r1_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_res, alu_par,
    output rsp_valid, rsp_id, rsp_data, rsp_par, rsp_err,
    input  rsp_ready,
    output par_err, op_count
  );

  modport slave (
    output r0_valid, r0_a, r0_b, r0_sel,
    input  r0_ready,
    output r1_valid, r1_a, r1_b, r1_sel,
    input  r1_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_res, alu_par,
    input  rsp_valid, rsp_id, rsp_data, rsp_par, rsp_err,
    output rsp_ready,
    input  par_err, op_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Round-robin arbiter and sequencer sharing one combinational 4-bit ALU
//   (8-bit result plus parity) between two requesters.
//
//   Flow: IDLE grants one requester (valid/ready handshake) and latches its
//   command onto the ALU pins. ISSUE holds the ALU inputs for SETTLE_CYCLES
//   cycles, then captures result and parity and checks the parity. RESP
//   presents a tagged response until the consumer takes it. A divide-by-zero
//   command (sel 3'b110 with b == 0) bypasses ISSUE and answers with rsp_err.
//
//   Parameters
//     SETTLE_CYCLES : cycles the ALU inputs are held before capture (1..15)
//     CNT_W         : width of the completed-operation counter
//
//   Ports
//     clk  : system clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : alu_arbiter_if.master carrying requester, ALU, response and
//            status signals (see alu_arbiter_if.sv)
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic            clk,
  input  logic            rst,
  alu_arbiter_if.master   bus
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("alu_arbiter: SETTLE_CYCLES must lie in 1..15");
  end

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Divide opcode with a zero divisor is refused without touching the ALU.
  function automatic logic is_reject(input logic [2:0] sel, input logic [3:0] b);
    return (sel == 3'b110) && (b == 4'd0);
  endfunction

  // The ALU claims alu_par is the XOR of its result; flag any disagreement.
  function automatic logic parity_bad(input logic [7:0] res, input logic par);
    return (^res) != par;
  endfunction

  state_t           state_q;
  logic             last_grant_q;
  logic [3:0]       wait_q;
  logic [3:0]       alu_a_q;
  logic [3:0]       alu_b_q;
  logic [2:0]       alu_sel_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [7:0]       rsp_data_q;
  logic             rsp_par_q;
  logic             rsp_err_q;
  logic             par_err_q;
  logic [CNT_W-1:0] op_count_q;

  logic             grant1;
  logic             r0_ready;
  logic             r1_ready;
  logic             accept;
  logic [3:0]       cmd_a_d;
  logic [3:0]       cmd_b_d;
  logic [2:0]       cmd_sel_d;

  // Grant is a pure function of the valids and the previous winner: a lone
  // valid always wins, a tie goes to whoever did not win last time. Ready is
  // suppressed while rst is high so a reset cycle never completes a handshake.
  always_comb begin
    grant1 = 1'b0;
    if (bus.r0_valid && bus.r1_valid) begin
      grant1 = ~last_grant_q;
    end else begin
      grant1 = bus.r1_valid;
    end

    r0_ready = 1'b0;
    r1_ready = 1'b0;
    if ((state_q == IDLE) && !rst) begin
      r0_ready = bus.r0_valid && !grant1;
      r1_ready = bus.r1_valid &&  grant1;
    end
    accept = r0_ready || r1_ready;

    cmd_a_d   = bus.r0_a;
    cmd_b_d   = bus.r0_b;
    cmd_sel_d = bus.r0_sel;
    if (grant1) begin
      cmd_a_d   = bus.r1_a;
      cmd_b_d   = bus.r1_b;
      cmd_sel_d = bus.r1_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      wait_q       <= 4'd0;
      alu_a_q      <= 4'd0;
      alu_b_q      <= 4'd0;
      alu_sel_q    <= 3'd0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= 8'd0;
      rsp_par_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
      par_err_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            alu_a_q      <= cmd_a_d;
            alu_b_q      <= cmd_b_d;
            alu_sel_q    <= cmd_sel_d;
            rsp_id_q     <= grant1;
            last_grant_q <= grant1;
            if (is_reject(cmd_sel_d, cmd_b_d)) begin
              rsp_data_q  <= 8'd0;
              rsp_par_q   <= 1'b0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              wait_q  <= SETTLE_LAST;
              state_q <= ISSUE;
            end
          end
        end

        ISSUE: begin
          // wait_q counts the remaining settle cycles after this one.
          if (wait_q == 4'd0) begin
            rsp_data_q  <= bus.alu_res;
            rsp_par_q   <= bus.alu_par;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            if (parity_bad(bus.alu_res, bus.alu_par)) begin
              par_err_q <= 1'b1;
            end
            state_q <= RESP;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + CNT_W'(1);
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.r0_ready  = r0_ready;
  assign bus.r1_ready  = r1_ready;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_par   = rsp_par_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.par_err   = par_err_q;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Self-checking bench for alu_arbiter. A behavioural ALU stub answers the
//   DUT's ALU pins (with an optional parity fault); directed scenario tasks
//   cover reset, single op, contention, back-pressure, divide-by-zero, parity
//   fault and reset mid-operation; a randomized run is checked against a
//   transaction-level timing/round-robin model.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
  localparam int S     = 3;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic fault_inj;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_arbiter_if #(.CNT_W(CNT_W)) bus ();

  alu_arbiter #(.SETTLE_CYCLES(S), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: any function mixing all three inputs will do.
  function automatic logic [7:0] stub_res(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] sel);
    logic [7:0] m;
    m = {sel, sel[1:0], sel};
    return {a, b} ^ m;
  endfunction

  assign bus.alu_res = stub_res(bus.alu_a, bus.alu_b, bus.alu_sel);
  assign bus.alu_par = (^bus.alu_res) ^ fault_inj;

  task automatic idle_inputs();
    bus.r0_valid = 1'b0; bus.r0_a = 4'd0; bus.r0_b = 4'd0; bus.r0_sel = 3'd0;
    bus.r1_valid = 1'b0; bus.r1_a = 4'd0; bus.r1_b = 4'd0; bus.r1_sel = 3'd0;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Count negedges until rsp_valid; -1 when the budget runs out.
  task automatic wait_rsp(output int n);
    int k;
    k = 0;
    n = -1;
    while (n < 0 && k < 40) begin
      @(negedge clk);
      k++;
      if (bus.rsp_valid === 1'b1) n = k;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fault_inj = 1'b0;
    idle_inputs();
    bus.r0_valid = 1'b1; bus.r1_valid = 1'b1; bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.r0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_r0_ready got %0b exp 0", bus.r0_ready); end
    n_tests++; if (bus.r1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_r1_ready got %0b exp 0", bus.r1_ready); end
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %0b exp 0", bus.rsp_valid); end
    n_tests++; if (bus.rsp_data !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_data got %h exp 00", bus.rsp_data); end
    n_tests++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id got %0b exp 0", bus.rsp_id); end
    n_tests++; if (bus.rsp_par !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_par got %0b exp 0", bus.rsp_par); end
    n_tests++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %0b exp 0", bus.rsp_err); end
    n_tests++; if (bus.par_err !== 1'b0) begin n_fail++; $display("FAIL reset_par_err got %0b exp 0", bus.par_err); end
    n_tests++; if (bus.op_count !== CNT_W'(0)) begin n_fail++; $display("FAIL reset_op_count got %0d exp 0", bus.op_count); end
    n_tests++; if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== 11'd0) begin n_fail++; $display("FAIL reset_alu_pins got %h exp 0", {bus.alu_a, bus.alu_b, bus.alu_sel}); end
    @(posedge clk);
    #1 rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single();
    int n;
    logic [7:0] e;
    apply_reset();
    e = stub_res(4'd3, 4'd5, 3'b101);
    bus.rsp_ready = 1'b1;
    bus.r0_valid = 1'b1; bus.r0_a = 4'd3; bus.r0_b = 4'd5; bus.r0_sel = 3'b101;
    @(negedge clk);
    n_tests++; if (bus.r0_ready !== 1'b1) begin n_fail++; $display("FAIL single_r0_ready got %0b exp 1", bus.r0_ready); end
    n_tests++; if (bus.r1_ready !== 1'b0) begin n_fail++; $display("FAIL single_r1_ready got %0b exp 0", bus.r1_ready); end
    @(posedge clk);
    #1 bus.r0_valid = 1'b0;
    wait_rsp(n);
    n_tests++; if (n != S + 1) begin n_fail++; $display("FAIL single_latency got %0d exp %0d", n, S + 1); end
    n_tests++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL single_rsp_id got %0b exp 0", bus.rsp_id); end
    n_tests++; if (bus.rsp_data !== e) begin n_fail++; $display("FAIL single_rsp_data got %h exp %h", bus.rsp_data, e); end
    n_tests++; if (bus.rsp_par !== ^e) begin n_fail++; $display("FAIL single_rsp_par got %0b exp %0b", bus.rsp_par, ^e); end
    n_tests++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL single_rsp_err got %0b exp 0", bus.rsp_err); end
    @(posedge clk);
    #1;
    n_tests++; if (bus.op_count !== CNT_W'(1)) begin n_fail++; $display("FAIL single_op_count got %0d exp 1", bus.op_count); end
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_drop got %0b exp 0", bus.rsp_valid); end
  endtask

  task automatic test_contention();
    int n;
    logic [7:0] e0, e1;
    apply_reset();
    e0 = stub_res(4'd1, 4'd2, 3'b010);
    e1 = stub_res(4'd5, 4'd3, 3'b011);
    bus.rsp_ready = 1'b1;
    bus.r0_valid = 1'b1; bus.r0_a = 4'd1; bus.r0_b = 4'd2; bus.r0_sel = 3'b010;
    bus.r1_valid = 1'b1; bus.r1_a = 4'd5; bus.r1_b = 4'd3; bus.r1_sel = 3'b011;
    @(negedge clk);
    n_tests++; if ({bus.r0_ready, bus.r1_ready} !== 2'b10) begin n_fail++; $display("FAIL cont_first_grant got %b exp 10", {bus.r0_ready, bus.r1_ready}); end
    wait_rsp(n);
    n_tests++; if (n != S + 1) begin n_fail++; $display("FAIL cont_lat0 got %0d exp %0d", n, S + 1); end
    n_tests++; if ({bus.rsp_id, bus.rsp_data, bus.rsp_par} !== {1'b0, e0, ^e0}) begin n_fail++; $display("FAIL cont_rsp0 got %h exp %h", {bus.rsp_id, bus.rsp_data, bus.rsp_par}, {1'b0, e0, ^e0}); end
    @(negedge clk);
    n_tests++; if ({bus.r0_ready, bus.r1_ready} !== 2'b01) begin n_fail++; $display("FAIL cont_second_grant got %b exp 01", {bus.r0_ready, bus.r1_ready}); end
    wait_rsp(n);
    n_tests++; if (n != S + 1) begin n_fail++; $display("FAIL cont_lat1 got %0d exp %0d", n, S + 1); end
    n_tests++; if ({bus.rsp_id, bus.rsp_data, bus.rsp_par} !== {1'b1, e1, ^e1}) begin n_fail++; $display("FAIL cont_rsp1 got %h exp %h", {bus.rsp_id, bus.rsp_data, bus.rsp_par}, {1'b1, e1, ^e1}); end
    @(negedge clk);
    n_tests++; if ({bus.r0_ready, bus.r1_ready} !== 2'b10) begin n_fail++; $display("FAIL cont_third_grant got %b exp 10", {bus.r0_ready, bus.r1_ready}); end
    n_tests++; if (bus.op_count !== CNT_W'(2)) begin n_fail++; $display("FAIL cont_op_count got %0d exp 2", bus.op_count); end
  endtask

  task automatic test_back_pressure();
    int n;
    logic [7:0] e;
    apply_reset();
    e = stub_res(4'd9, 4'd4, 3'b001);
    bus.r0_valid = 1'b1; bus.r0_a = 4'd9; bus.r0_b = 4'd4; bus.r0_sel = 3'b001;
    @(posedge clk);
    #1 bus.r1_valid = 1'b1; bus.r1_a = 4'd2; bus.r1_sel = 3'b100;
    wait_rsp(n);
    n_tests++; if (n != S + 1) begin n_fail++; $display("FAIL bp_latency got %0d exp %0d", n, S + 1); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_par, bus.rsp_err} !== {1'b1, 1'b0, e, ^e, 1'b0}) begin n_fail++; $display("FAIL bp_hold%0d got %h exp %h", i, {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_par, bus.rsp_err}, {1'b1, 1'b0, e, ^e, 1'b0}); end
      n_tests++; if ({bus.r0_ready, bus.r1_ready} !== 2'b00) begin n_fail++; $display("FAIL bp_ready%0d got %b exp 00", i, {bus.r0_ready, bus.r1_ready}); end
      n_tests++; if (bus.op_count !== CNT_W'(0)) begin n_fail++; $display("FAIL bp_count%0d got %0d exp 0", i, bus.op_count); end
    end
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0; bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    n_tests++; if (bus.op_count !== CNT_W'(1)) begin n_fail++; $display("FAIL bp_count_after got %0d exp 1", bus.op_count); end
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_rsp_drop got %0b exp 0", bus.rsp_valid); end
  endtask

  task automatic test_div_zero();
    int n;
    apply_reset();
    bus.rsp_ready = 1'b1;
    bus.r1_valid = 1'b1; bus.r1_a = 4'd7; bus.r1_b = 4'd0; bus.r1_sel = 3'b110;
    @(negedge clk);
    n_tests++; if ({bus.r0_ready, bus.r1_ready} !== 2'b01) begin n_fail++; $display("FAIL dz_grant got %b exp 01", {bus.r0_ready, bus.r1_ready}); end
    @(posedge clk);
    #1 bus.r1_valid = 1'b0;
    wait_rsp(n);
    n_tests++; if (n != 1) begin n_fail++; $display("FAIL dz_latency got %0d exp 1", n); end
    n_tests++; if ({bus.rsp_id, bus.rsp_data, bus.rsp_par, bus.rsp_err} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin n_fail++; $display("FAIL dz_rsp got %h exp %h", {bus.rsp_id, bus.rsp_data, bus.rsp_par, bus.rsp_err}, {1'b1, 8'h00, 1'b0, 1'b1}); end
    n_tests++; if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== {4'd7, 4'd0, 3'b110}) begin n_fail++; $display("FAIL dz_alu_pins got %h exp %h", {bus.alu_a, bus.alu_b, bus.alu_sel}, {4'd7, 4'd0, 3'b110}); end
    @(posedge clk);
    #1;
    n_tests++; if (bus.op_count !== CNT_W'(1)) begin n_fail++; $display("FAIL dz_op_count got %0d exp 1", bus.op_count); end
  endtask

  task automatic test_parity_fault();
    int n;
    apply_reset();
    bus.rsp_ready = 1'b1;
    fault_inj = 1'b1;
    // stub gives 0x01 for a=0 b=1 sel=0; the fault drives its parity to 0
    bus.r0_valid = 1'b1; bus.r0_a = 4'd0; bus.r0_b = 4'd1; bus.r0_sel = 3'd0;
    @(negedge clk);
    n_tests++; if (bus.par_err !== 1'b0) begin n_fail++; $display("FAIL pf_before got %0b exp 0", bus.par_err); end
    @(posedge clk);
    #1 bus.r0_valid = 1'b0;
    wait_rsp(n);
    n_tests++; if (bus.par_err !== 1'b1) begin n_fail++; $display("FAIL pf_set got %0b exp 1", bus.par_err); end
    n_tests++; if ({bus.rsp_data, bus.rsp_par} !== {8'h01, 1'b0}) begin n_fail++; $display("FAIL pf_rsp got %h exp %h", {bus.rsp_data, bus.rsp_par}, {8'h01, 1'b0}); end
    @(posedge clk);
    #1 fault_inj = 1'b0;
    bus.r1_valid = 1'b1; bus.r1_a = 4'd2; bus.r1_b = 4'd3; bus.r1_sel = 3'd4;
    @(posedge clk);
    #1 bus.r1_valid = 1'b0;
    wait_rsp(n);
    n_tests++; if ({bus.rsp_id, bus.rsp_err} !== 2'b10) begin n_fail++; $display("FAIL pf_good_rsp got %b exp 10", {bus.rsp_id, bus.rsp_err}); end
    n_tests++; if (bus.par_err !== 1'b1) begin n_fail++; $display("FAIL pf_sticky got %0b exp 1", bus.par_err); end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_tests++; if (bus.par_err !== 1'b0) begin n_fail++; $display("FAIL pf_clear got %0b exp 0", bus.par_err); end
  endtask

  task automatic test_reset_mid_op();
    int n;
    logic [7:0] e;
    apply_reset();
    e = stub_res(4'd1, 4'd1, 3'd1);
    bus.rsp_ready = 1'b1;
    bus.r0_valid = 1'b1; bus.r0_a = 4'd6; bus.r0_b = 4'd6; bus.r0_sel = 3'd7;
    @(negedge clk);
    n_tests++; if (bus.r0_ready !== 1'b1) begin n_fail++; $display("FAIL rmo_grant got %0b exp 1", bus.r0_ready); end
    @(posedge clk);
    #1 bus.r0_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.r0_valid = 1'b1; bus.r0_a = 4'd1; bus.r0_b = 4'd1; bus.r0_sel = 3'd1;
    bus.r1_valid = 1'b1; bus.r1_a = 4'd2; bus.r1_b = 4'd2; bus.r1_sel = 3'd2;
    @(negedge clk);
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmo_rsp_valid got %0b exp 0", bus.rsp_valid); end
    n_tests++; if (bus.op_count !== CNT_W'(0)) begin n_fail++; $display("FAIL rmo_op_count got %0d exp 0", bus.op_count); end
    n_tests++; if ({bus.r0_ready, bus.r1_ready} !== 2'b10) begin n_fail++; $display("FAIL rmo_next_grant got %b exp 10", {bus.r0_ready, bus.r1_ready}); end
    @(posedge clk);
    #1 bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    wait_rsp(n);
    n_tests++; if (n != S + 1) begin n_fail++; $display("FAIL rmo_latency got %0d exp %0d", n, S + 1); end
    n_tests++; if ({bus.rsp_id, bus.rsp_data} !== {1'b0, e}) begin n_fail++; $display("FAIL rmo_rsp got %h exp %h", {bus.rsp_id, bus.rsp_data}, {1'b0, e}); end
  endtask

  // Transaction-level model: a command accepted at cycle c answers from cycle
  // c+1 (rejected) or c+S+1 (normal) until the response is taken; while an
  // operation is outstanding nobody is granted.
  task automatic test_random();
    bit busy, last, rej, cid, exp_v, g, e0, e1, v0, v1;
    int rsp_at, cyc, cnt;
    logic [3:0] a0, b0, a1, b1, ca, cb;
    logic [2:0] s0, s1, cs;
    logic [7:0] exp_d;
    busy = 1'b0; last = 1'b1; rej = 1'b0; cid = 1'b0;
    rsp_at = 0; cyc = 0; cnt = 0;
    ca = 4'd0; cb = 4'd0; cs = 3'd0; exp_d = 8'd0;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      a0 = 4'($urandom); a1 = 4'($urandom);
      b0 = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      b1 = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      s0 = ($urandom_range(0, 2) == 0) ? 3'd6 : 3'($urandom);
      s1 = ($urandom_range(0, 2) == 0) ? 3'd6 : 3'($urandom);
      bus.r0_valid = v0; bus.r0_a = a0; bus.r0_b = b0; bus.r0_sel = s0;
      bus.r1_valid = v1; bus.r1_a = a1; bus.r1_b = b1; bus.r1_sel = s1;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_v = busy && (cyc >= rsp_at);
      g  = (v0 && v1) ? !last : v1;
      e0 = !busy && v0 && !g;
      e1 = !busy && v1 && g;
      n_tests++; if ({bus.r0_ready, bus.r1_ready} !== {e0, e1}) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, {bus.r0_ready, bus.r1_ready}, {e0, e1}); end
      n_tests++; if (bus.rsp_valid !== exp_v) begin n_fail++; $display("FAIL rnd_rsp_valid cyc %0d got %0b exp %0b", cyc, bus.rsp_valid, exp_v); end
      n_tests++; if (bus.op_count !== CNT_W'(cnt)) begin n_fail++; $display("FAIL rnd_op_count cyc %0d got %0d exp %0d", cyc, bus.op_count, CNT_W'(cnt)); end
      n_tests++; if (bus.par_err !== 1'b0) begin n_fail++; $display("FAIL rnd_par_err cyc %0d got %0b exp 0", cyc, bus.par_err); end
      if (exp_v) begin
        n_tests++; if ({bus.rsp_id, bus.rsp_data, bus.rsp_par, bus.rsp_err} !== {cid, exp_d, ^exp_d, rej}) begin n_fail++; $display("FAIL rnd_rsp cyc %0d got %h exp %h", cyc, {bus.rsp_id, bus.rsp_data, bus.rsp_par, bus.rsp_err}, {cid, exp_d, ^exp_d, rej}); end
      end
      if (busy) begin
        n_tests++; if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== {ca, cb, cs}) begin n_fail++; $display("FAIL rnd_alu_pins cyc %0d got %h exp %h", cyc, {bus.alu_a, bus.alu_b, bus.alu_sel}, {ca, cb, cs}); end
      end
      if (!busy && (v0 || v1)) begin
        busy = 1'b1;
        cid  = g;
        last = g;
        ca = g ? a1 : a0;
        cb = g ? b1 : b0;
        cs = g ? s1 : s0;
        rej = (cs == 3'd6) && (cb == 4'd0);
        exp_d = rej ? 8'd0 : stub_res(ca, cb, cs);
        rsp_at = cyc + (rej ? 1 : S + 1);
      end else if (exp_v && bus.rsp_ready) begin
        busy = 1'b0;
        cnt++;
      end
      cyc++;
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    fault_inj = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_div_zero();
    test_parity_fault();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational 4-bit ALU (8-bit result plus parity) between two requesters.
- It accepts an opcode and operands from a requester over a valid/ready handshake, then drives the ALU and waits a programmable settle time.
- It captures the result and parity, checks the parity, and returns a tagged response over a shared valid/ready response channel.
- It sits between the two datapath clients and the ALU instance.

Parameters:
SETTLE_CYCLES, 1, number of cycles the ALU inputs are held before capture (legal range 1..15)
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
r0_valid  input  1  requester 0 command valid
r0_ready  output  1  requester 0 command accepted this cycle
r0_a  input  4  requester 0 operand A
r0_b  input  4  requester 0 operand B
r0_sel  input  3  requester 0 opcode
r1_valid  input  1  requester 1 command valid
r1_ready  output  1  requester 1 command accepted this cycle
r1_a  input  4  requester 1 operand A
r1_b  input  4  requester 1 operand B
r1_sel  input  3  requester 1 opcode
alu_a  output  4  operand A to ALU
alu_b  output  4  operand B to ALU
alu_sel  output  3  opcode to ALU
alu_res  input  8  ALU result
alu_par  input  1  ALU parity (XOR of result)
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed
rsp_id  output  1  requester that issued the command
rsp_data  output  8  captured result
rsp_par  output  1  captured ALU parity
rsp_err  output  1  command rejected (divide-by-zero)
par_err  output  1  sticky parity-mismatch flag
op_count  output  CNT_W  completed responses, wraps at 2^CNT_W

Behaviour:
- Reset:
  - rst is sampled on the clock edge.
  - State goes to IDLE.
  - All outputs go to 0: r*_ready, alu_a/b/sel, rsp_*, par_err, op_count.
  - last_grant is set to 1, so r0 wins the first contention.
  - rst overrides everything, including mid-operation. An operation in flight is dropped, no response is produced and op_count does not increment.
- States are IDLE, ISSUE, RESP.
- IDLE:
  - Grant is combinational from valids. With one valid, that requester is granted. With both valid, the requester not equal to last_grant is granted.
  - rN_ready is high only in IDLE, only for the granted requester, and only when rN_valid is high. At most one ready is high per cycle.
  - On handshake, latch a/b/sel into alu_a/b/sel, record rsp_id, and update last_grant.
- Normal command:
  - ISSUE lasts exactly SETTLE_CYCLES cycles and uses a wait counter.
  - At the clock edge ending the last ISSUE cycle:
    - rsp_data<=alu_res and rsp_par<=alu_par.
    - rsp_err<=0.
    - If ^alu_res != alu_par, par_err<=1.
    - State goes to RESP.
- Rejected command (sel==3'b110 and b==0):
  - Skip ISSUE and go from IDLE straight to RESP.
  - rsp_data=0, rsp_par=0, rsp_err=1.
  - alu_a/b/sel still latch the command.
- Latency: a command handshake in cycle c puts rsp_valid high in cycle c+SETTLE_CYCLES+1. A rejected command puts it high in cycle c+1.
- RESP:
  - rsp_valid=1 and all rsp_* are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: op_count<=op_count+1 (wraps), then next state IDLE with rsp_valid=0.
  - No new command is accepted during ISSUE or RESP. Peak throughput is one op per SETTLE_CYCLES+2 cycles.
- alu_a/b/sel hold their last value in IDLE and RESP.
- par_err clears only on rst.
- Requesters may change a/b/sel while not handshaken. Only values at the handshake are used.

Test Plan:
- Single op, no contention: rst, then r0 sends sel=101 a=3 b=5 -> r0_ready for 1 cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_data=0x35, rsp_par=0, rsp_err=0; op_count=1 after the handshake.
- Contention: r0 and r1 both valid (r0 sel=010 a=1 b=2; r1 sel=011 a=5 b=3) -> r0 served first with data 0x33, par 0; then r1 with data 0x68, par 1; then with both still valid, r0 is granted again.
- Back-pressure: hold rsp_ready=0 for 5 cycles during RESP -> rsp_* stable, no ready to either requester, op_count unchanged until the handshake.
- Divide-by-zero: r1 sends sel=110 a=7 b=0 -> rsp_valid next cycle, rsp_err=1, rsp_data=0, rsp_id=1; op_count increments.
- Parity fault: stub returns alu_res=0x01 with alu_par=0 -> par_err=1 after capture and stays 1 across later good ops until rst.
- Reset mid-op: SETTLE_CYCLES=3, assert rst in the 2nd ISSUE cycle -> next cycle IDLE, rsp_valid=0, op_count unchanged, and r0 wins the next contention.
